// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//   Shared types and constants for the MIPS memory subsystem.
//
//   arb_state_t : states of the unified-memory arbiter FSM
//   PORT_C      : port id of the MIPS core requester
//   PORT_D      : port id of the debug / program-loader requester
//   CNT_W       : width of the wait-state counter (WAIT is 0..15)
// ---------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int CNT_W = 4;

endpackage : mips_pkg

// File: rtl/arb_pick.sv
// ---------------------------------------------------------------------------
// arb_pick
//   Combinational two-way winner select. Kept stand-alone so the same picker
//   can later arbitrate a split I-cache / D-cache pair.
//
//   Parameters:
//     RR          1 = round-robin on a tie, 0 = fixed priority (port C wins)
//   Ports:
//     c_req       in   request from port C
//     d_req       in   request from port D
//     last_grant  in   port id that won the previous grant
//     any_req     out  at least one request is pending
//     winner      out  port id that wins this evaluation (valid if any_req)
// ---------------------------------------------------------------------------
module arb_pick
    import mips_pkg::*;
#(
    parameter int RR = 1
) (
    input  logic c_req,
    input  logic d_req,
    input  logic last_grant,
    output logic any_req,
    output logic winner
);

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        any_req = c_req | d_req;
        winner  = PORT_C;
        if (c_req && d_req) begin
            // On a tie, round-robin hands the grant to whoever did not win
            // last time; fixed priority always favours the core.
            winner = (RR != 0) ? ~last_grant : PORT_C;
        end else if (d_req) begin
            winner = PORT_D;
        end
    end

endmodule : arb_pick

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares the single unified memory port between the MIPS core (port C) and
//   the debug / program-loader port (port D). One transaction at a time is
//   serialised through an IDLE -> ACCESS -> RESP FSM; ACCESS lasts WAIT+1
//   cycles and the single write strobe is issued in its final cycle.
//
//   Parameters:
//     N      address / data width
//     WAIT   extra memory access cycles per transaction (0..15)
//     RR     1 = round-robin arbitration, 0 = fixed priority (port C wins)
//   Ports:
//     clk, reset            clock (rising edge), async active-high reset
//     c_req/c_we/c_addr/c_wdata  core request and operands
//     c_ack, c_rdata        core completion pulse and read data
//     d_req/d_we/d_addr/d_wdata  loader request and operands
//     d_ack, d_rdata        loader completion pulse and read data
//     mem_we/mem_addr/mem_wdata  memory write strobe, address, write data
//     mem_rdata             memory read data, combinational from mem_addr
//     busy                  FSM is not in IDLE
//     grant_id              owner of the current / last transaction
// ---------------------------------------------------------------------------
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int N    = 32,
    parameter int WAIT = 0,
    parameter int RR   = 1
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         c_req,
    input  logic         c_we,
    input  logic [N-1:0] c_addr,
    input  logic [N-1:0] c_wdata,
    output logic         c_ack,
    output logic [N-1:0] c_rdata,

    input  logic         d_req,
    input  logic         d_we,
    input  logic [N-1:0] d_addr,
    input  logic [N-1:0] d_wdata,
    output logic         d_ack,
    output logic [N-1:0] d_rdata,

    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata,

    output logic         busy,
    output logic         grant_id
);

    localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT);

    arb_state_t       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             last_q,    last_d;
    logic             grant_q,   grant_d;
    logic             we_q,      we_d;
    logic [N-1:0]     addr_q,    addr_d;
    logic [N-1:0]     wdata_q,   wdata_d;
    logic [N-1:0]     c_rdata_q, c_rdata_d;
    logic [N-1:0]     d_rdata_q, d_rdata_d;

    logic             any_req;
    logic             pick;

    arb_pick #(
        .RR         (RR)
    ) u_pick (
        .c_req      (c_req),
        .d_req      (d_req),
        .last_grant (last_q),
        .any_req    (any_req),
        .winner     (pick)
    );

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    // NOTE: the operand and read-data registers are reset as well, because
    // mem_addr, mem_wdata and both rdata outputs must read 0 out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= PORT_D;   // so port C wins the first tie
            grant_q   <= PORT_C;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            c_rdata_q <= c_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath-update logic
    // -----------------------------------------------------------------------
    always_comb begin : next_state
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        grant_d   = grant_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        c_rdata_d = c_rdata_q;
        d_rdata_d = d_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    // Operands are captured here so the requester may change
                    // them freely once the grant has been taken.
                    state_d = ACCESS;
                    grant_d = pick;
                    last_d  = pick;
                    cnt_d   = WAIT_CNT;
                    if (pick == PORT_D) begin
                        we_d    = d_we;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                    end else begin
                        we_d    = c_we;
                        addr_d  = c_addr;
                        wdata_d = c_wdata;
                    end
                end
            end

            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Last access cycle: the write strobe is active now and
                    // the memory's read data is sampled into the winner's
                    // register (pre-write contents for a write).
                    state_d = RESP;
                    if (grant_q == PORT_D) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        c_rdata_d = mem_rdata;
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs (decoded from registered state only)
    // -----------------------------------------------------------------------
    always_comb begin : outputs
        busy      = (state_q != IDLE);
        c_ack     = (state_q == RESP) && (grant_q == PORT_C);
        d_ack     = (state_q == RESP) && (grant_q == PORT_D);
        // Strobe only in the final ACCESS cycle: one write pulse per write,
        // however many wait states are configured.
        mem_we    = (state_q == ACCESS) && we_q && (cnt_q == '0);
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        c_rdata   = c_rdata_q;
        d_rdata   = d_rdata_q;
        grant_id  = grant_q;
    end

endmodule : mem_arbiter
